// File: rtl/candy_sram_arb.sv
// candy_sram_arb: round-robin arbiter sequencing instruction-fetch and data ports onto the shared candy_sram,
// with variable-latency read wait and read timeout.
module candy_sram_arb #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              sram_read_enable,
    output logic [ADDR_W-1:0] sram_raddr,
    input  logic [DATA_W-1:0] sram_rdata,
    input  logic              sram_rdata_ready,
    output logic              sram_write_enable,
    output logic [ADDR_W-1:0] sram_waddr,
    output logic [DATA_W-1:0] sram_wdata,
    output logic              busy,
    output logic              owner
);
    typedef enum logic [1:0] {IDLE, RD, WR} state_t;
    state_t            r_state, w_state;
    logic              r_owner, w_owner;
    logic [7:0]        r_cnt, w_cnt;
    logic              r_i_done, w_i_done, r_d_done, w_d_done;
    logic              r_i_err, w_i_err, r_d_err, w_d_err;
    logic [DATA_W-1:0] r_i_rdata, w_i_rdata, r_d_rdata, w_d_rdata;
    logic              r_re, w_re, r_we, w_we;
    logic [ADDR_W-1:0] r_raddr, w_raddr, r_waddr, w_waddr;
    logic [DATA_W-1:0] r_wdata, w_wdata;
    logic              w_i_elig, w_d_elig, w_win, w_tout, w_end;

    // a port is masked in its own done cycle so a held req is not re-granted immediately
    assign w_i_elig = i_req && !r_i_done;
    assign w_d_elig = d_req && !r_d_done;
    assign w_win    = (w_i_elig && w_d_elig) ? ~r_owner : w_d_elig;
    assign w_tout   = r_cnt == 8'(TIMEOUT_CYC - 1);
    assign w_end    = sram_rdata_ready || w_tout;

    always_comb begin
        w_state   = r_state;
        w_owner   = r_owner;
        w_cnt     = r_cnt;
        w_i_done  = 1'b0;
        w_d_done  = 1'b0;
        w_i_err   = r_i_err;
        w_d_err   = r_d_err;
        w_i_rdata = r_i_rdata;
        w_d_rdata = r_d_rdata;
        w_re      = r_re;
        w_raddr   = r_raddr;
        w_we      = 1'b0;
        w_waddr   = r_waddr;
        w_wdata   = r_wdata;
        case (r_state)
            IDLE: begin
                if (w_i_elig || w_d_elig) begin
                    w_owner = w_win;
                    if (w_win && d_we) begin
                        w_state = WR;
                        w_we    = 1'b1;
                        w_waddr = d_addr;
                        w_wdata = d_wdata;
                    end else begin
                        w_state = RD;
                        w_re    = 1'b1;
                        w_raddr = w_win ? d_addr : i_addr;
                        w_cnt   = 8'd0;
                    end
                end
            end
            WR: begin
                w_state  = IDLE;
                w_d_done = 1'b1;
                w_d_err  = 1'b0;
            end
            RD: begin
                if (w_end) begin
                    w_state = IDLE;
                    w_re    = 1'b0;
                    if (r_owner) begin
                        w_d_done  = 1'b1;
                        w_d_err   = !sram_rdata_ready;
                        w_d_rdata = sram_rdata_ready ? sram_rdata : '0;
                    end else begin
                        w_i_done  = 1'b1;
                        w_i_err   = !sram_rdata_ready;
                        w_i_rdata = sram_rdata_ready ? sram_rdata : '0;
                    end
                end else begin
                    w_cnt = r_cnt + 8'd1;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_owner   <= 1'b1;
            r_cnt     <= '0;
            r_i_done  <= 1'b0;
            r_d_done  <= 1'b0;
            r_i_err   <= 1'b0;
            r_d_err   <= 1'b0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
            r_re      <= 1'b0;
            r_raddr   <= '0;
            r_we      <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
        end else begin
            r_state   <= w_state;
            r_owner   <= w_owner;
            r_cnt     <= w_cnt;
            r_i_done  <= w_i_done;
            r_d_done  <= w_d_done;
            r_i_err   <= w_i_err;
            r_d_err   <= w_d_err;
            r_i_rdata <= w_i_rdata;
            r_d_rdata <= w_d_rdata;
            r_re      <= w_re;
            r_raddr   <= w_raddr;
            r_we      <= w_we;
            r_waddr   <= w_waddr;
            r_wdata   <= w_wdata;
        end
    end

    assign i_done            = r_i_done;
    assign i_rdata           = r_i_rdata;
    assign i_err             = r_i_err;
    assign d_done            = r_d_done;
    assign d_rdata           = r_d_rdata;
    assign d_err             = r_d_err;
    assign sram_read_enable  = r_re;
    assign sram_raddr        = r_raddr;
    assign sram_write_enable = r_we;
    assign sram_waddr        = r_waddr;
    assign sram_wdata        = r_wdata;
    assign busy              = r_state != IDLE;
    assign owner             = r_owner;
endmodule

// File: tb/tb_candy_sram_arb.sv
// tb_candy_sram_arb: directed checks of grant order, read/write sequencing, timeout and reset abort.
module tb_candy_sram_arb;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [9:0]  i_addr = '0, d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        i_done, i_err, d_done, d_err;
    logic [31:0] i_rdata, d_rdata;
    logic        sram_read_enable, sram_write_enable, sram_rdata_ready;
    logic [9:0]  sram_raddr, sram_waddr;
    logic [31:0] sram_rdata, sram_wdata;
    logic        busy, owner;
    logic        use_fixed = 1'b1, force_ready = 1'b0;
    logic [31:0] fixed_val = 32'hDEADBEEF;
    int          lat = 0;
    int          rd_cnt = 0;
    int          n_chk = 0, n_pass = 0;

    candy_sram_arb dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
        .sram_read_enable(sram_read_enable), .sram_raddr(sram_raddr),
        .sram_rdata(sram_rdata), .sram_rdata_ready(sram_rdata_ready),
        .sram_write_enable(sram_write_enable), .sram_waddr(sram_waddr), .sram_wdata(sram_wdata),
        .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    // SRAM model: ready in read-enable cycle number lat (lat=0 means never)
    always @(posedge clk) rd_cnt <= sram_read_enable ? rd_cnt + 1 : 0;
    assign sram_rdata_ready = force_ready || (sram_read_enable && lat != 0 && rd_cnt == lat - 1);
    assign sram_rdata = use_fixed ? fixed_val : {16'hCAFE, 6'd0, sram_raddr};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int i_cnt, d_cnt, n;

    initial begin
        tick();
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_owner", owner, 1);
        check("rst_re", sram_read_enable, 0);
        check("rst_we", sram_write_enable, 0);
        check("rst_idone", i_done, 0);
        check("rst_ddone", d_done, 0);
        check("rst_irdata", i_rdata, 0);
        check("rst_drdata", d_rdata, 0);

        // 1: instruction read, ready latency 2
        i_req = 1'b1; i_addr = 10'h010; lat = 2;
        tick();
        check("t1_re", sram_read_enable, 1);
        check("t1_raddr", sram_raddr, 10'h010);
        check("t1_owner", owner, 0);
        check("t1_busy", busy, 1);
        tick();
        check("t1_re2", sram_read_enable, 1);
        check("t1_raddr2", sram_raddr, 10'h010);
        check("t1_nodone", i_done, 0);
        tick();
        i_req = 1'b0;
        check("t1_done", i_done, 1);
        check("t1_rdata", i_rdata, 32'hDEADBEEF);
        check("t1_err", i_err, 0);
        check("t1_re_off", sram_read_enable, 0);
        check("t1_idle", busy, 0);
        tick();
        check("t1_pulse", i_done, 0);
        check("t1_hold", i_rdata, 32'hDEADBEEF);

        // 2: data write
        d_req = 1'b1; d_we = 1'b1; d_addr = 10'h3FF; d_wdata = 32'h12345678;
        tick();
        check("t2_we", sram_write_enable, 1);
        check("t2_waddr", sram_waddr, 10'h3FF);
        check("t2_wdata", sram_wdata, 32'h12345678);
        check("t2_re", sram_read_enable, 0);
        check("t2_owner", owner, 1);
        tick();
        d_req = 1'b0;
        check("t2_we_off", sram_write_enable, 0);
        check("t2_done", d_done, 1);
        check("t2_err", d_err, 0);
        check("t2_re2", sram_read_enable, 0);
        tick();
        check("t2_pulse", d_done, 0);

        // 3: both requesting reads, latency 1, alternating grants
        rst = 1'b1; tick(); rst = 1'b0;
        use_fixed = 1'b0; lat = 1; d_we = 1'b0;
        i_addr = 10'h020; d_addr = 10'h040; i_req = 1'b1; d_req = 1'b1;
        i_cnt = 0; d_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("t3_owner%0d", k), owner, k % 2);
            check($sformatf("t3_raddr%0d", k), sram_raddr, (k % 2) ? 10'h040 : 10'h020);
            tick();
            i_cnt += i_done;
            d_cnt += d_done;
            if (k % 2) check($sformatf("t3_drdata%0d", k), d_rdata, 32'hCAFE0040);
            else       check($sformatf("t3_irdata%0d", k), i_rdata, 32'hCAFE0020);
            if (k == 7) begin i_req = 1'b0; d_req = 1'b0; end
        end
        check("t3_icnt", i_cnt, 4);
        check("t3_dcnt", d_cnt, 4);

        // 4: read timeout, then a normal read
        i_addr = 10'h055; lat = 0; i_req = 1'b1;
        tick();
        n = 0;
        while (sram_read_enable && n < 40) begin n++; tick(); end
        check("t4_re_cycles", n, 16);
        check("t4_done", i_done, 1);
        check("t4_err", i_err, 1);
        check("t4_rdata", i_rdata, 0);
        lat = 1;
        tick();
        check("t4_mask_re", sram_read_enable, 0);
        check("t4_mask_done", i_done, 0);
        tick();
        check("t4_regrant", sram_read_enable, 1);
        tick();
        i_req = 1'b0;
        check("t4_done2", i_done, 1);
        check("t4_err2", i_err, 0);
        check("t4_rdata2", i_rdata, 32'hCAFE0055);
        tick();

        // 5: reset during a data read
        d_addr = 10'h077; lat = 0; d_req = 1'b1;
        tick();
        check("t5_re", sram_read_enable, 1);
        check("t5_owner", owner, 1);
        tick();
        rst = 1'b1; d_req = 1'b0;
        tick();
        rst = 1'b0;
        check("t5_busy", busy, 0);
        check("t5_re_off", sram_read_enable, 0);
        check("t5_ddone", d_done, 0);
        check("t5_drdata", d_rdata, 0);
        check("t5_owner_rst", owner, 1);
        force_ready = 1'b1;
        tick();
        force_ready = 1'b0;
        check("t5_late_done", d_done, 0);
        check("t5_late_busy", busy, 0);
        check("t5_late_rdata", d_rdata, 0);

        // 6: held instruction req, latency 1: done every 3 cycles
        i_addr = 10'h0AA; lat = 1; i_req = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            check($sformatf("t6_done%0d", c), i_done, (c % 3) == 2);
            check($sformatf("t6_re%0d", c), sram_read_enable, (c % 3) == 1);
        end
        i_req = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/candy_sram_arb.md
Name: candy_sram_arb

Overview:
Arbiter and sequencer for the single shared candy_sram. It multiplexes two requesters onto the SRAM read/write ports:
- the instruction-fetch port (read only);
- the data port (load/store, read or write).

It enforces a req/done handshake, waits on the variable-latency read-ready, applies round-robin fairness, and flags read timeouts. It sits between candy_if / the load-store logic and candy_sram in the candy top.

Parameters:
ADDR_W, 10, SRAM address width in bits
DATA_W, 32, SRAM data width in bits
TIMEOUT_CYC, 16, max cycles waiting for sram_rdata_ready before a read is aborted (must be 1..255)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous reset, active-high
i_req  input  1  instruction read request; held until i_done
i_addr  input  ADDR_W  instruction read address; stable while i_req
i_done  output  1  one-cycle completion pulse, instruction port
i_rdata  output  DATA_W  instruction read data; valid when i_done=1, held until next i_done
i_err  output  1  timeout flag; valid with i_done
d_req  input  1  data request; held until d_done
d_we  input  1  1=write, 0=read; stable while d_req
d_addr  input  ADDR_W  data address; stable while d_req
d_wdata  input  DATA_W  write data; stable while d_req
d_done  output  1  one-cycle completion pulse, data port
d_rdata  output  DATA_W  data read result; valid when d_done=1, held until next d_done
d_err  output  1  timeout flag; valid with d_done
sram_read_enable  output  1  SRAM read enable
sram_raddr  output  ADDR_W  SRAM read address
sram_rdata  input  DATA_W  SRAM read data
sram_rdata_ready  input  1  SRAM read data valid
sram_write_enable  output  1  SRAM write enable
sram_waddr  output  ADDR_W  SRAM write address
sram_wdata  output  DATA_W  SRAM write data
busy  output  1  1 when state != IDLE
owner  output  1  current/last grant: 0=instruction, 1=data

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; all enables, done and err outputs 0; rdata outputs 0; busy 0.
  - owner=1, so the first tie goes to instruction.
  - Timeout counter 0.
  - An in-flight transaction is dropped with no done pulse.
- All outputs are registered.
- States: IDLE, RD, WR.
- IDLE:
  - Eligible req = req high and that port's done not asserted this cycle. A requester may hold req through done; it is re-granted from the following cycle.
  - One eligible: grant it. Both eligible: grant the port != owner. None: stay.
  - On grant: owner<=winner; latch address/data.
  - Read grant: state<=RD, sram_read_enable<=1, sram_raddr<=addr, counter<=0.
  - Write grant (data port, d_we=1): state<=WR, sram_write_enable<=1, sram_waddr/sram_wdata<=d_addr/d_wdata.
- WR: sram_write_enable is high for exactly this one cycle. At the edge: write_enable<=0, d_done<=1, d_err<=0, state<=IDLE. A write completes with done 2 cycles after the req edge.
- RD:
  - sram_read_enable and sram_raddr are held constant until exit.
  - If sram_rdata_ready=1: capture sram_rdata into the owner's rdata; owner done<=1, err<=0; read_enable<=0; state<=IDLE.
  - Else if counter==TIMEOUT_CYC-1: owner done<=1, err<=1, rdata<=0, read_enable<=0, state<=IDLE.
  - Else counter+1 (8-bit, saturating not required given the parameter bound).
- Latency: read with ready in RD cycle k (k=1 first) gives done in cycle k+1 after the grant edge.
- sram_rdata_ready in IDLE or WR is ignored.
- done pulses last exactly one cycle.
- Non-owner outputs are unchanged during another port's transaction.
- Only one transaction is outstanding at a time; read and write enables are never high together.
- Requester protocol violations (req dropped before done) are not detected. The transaction completes and done is still pulsed.

Test Plan:
1. Reset, i_req=1, i_addr=0x010, SRAM ready 2 cycles after read_enable with data 0xDEADBEEF -> sram_raddr=0x010 held 2 cycles; i_done single pulse, i_rdata=0xDEADBEEF, i_err=0, owner=0.
2. d_req=1, d_we=1, d_addr=0x3FF, d_wdata=0x12345678 -> sram_write_enable high exactly 1 cycle with waddr 0x3FF, wdata 0x12345678; d_done next cycle; no read_enable.
3. i_req and d_req both held high (d_we=0) from reset, SRAM ready latency 1 -> grants alternate I,D,I,D; sram_raddr tracks the owner's address; each port gets 4 dones in 8 transactions.
4. i_req=1, sram_rdata_ready never asserted -> read_enable high exactly 16 cycles; i_done with i_err=1, i_rdata=0; next i_req then completes normally with err=0.
5. d read granted, rst asserted in RD cycle 2 -> next cycle all outputs 0, busy=0, no d_done; a late sram_rdata_ready after reset is ignored.
6. i_req held continuously, ready latency 1 -> done every 3 cycles (grant, RD, done/IDLE mask); req never re-granted in its own done cycle.
